// File: rtl/hub75_scan_ctrl.sv
// ---------------------------------------------------------------------------
// hub75_scan_ctrl
//
// Scan sequencer for a 64x64 HUB75 panel driven from a dual-half sprite ROM.
// For every (row, plane) pair it shifts 64 columns of RGB bits into the panel,
// latches them, and then drives the output-enable for a binary-weighted time.
// Planes are sent LSB first. Plane p uses bit (8-COLOR_BITS+p) of each
// channel and is shown for BASE_ON<<p cycles.
//
// Optional feature macro: SCAN_BRIGHTNESS_EN
//   When defined, a 4-bit brightness input is added. It shortens the
//   output-enable window inside SHOW, but the SHOW length stays the same so
//   frame timing is constant.
//
// Ports
//   clk, rst_n          clock; asynchronous active-low reset
//   enable              start scanning; sampled only at frame boundaries
//   brightness[3:0]     (SCAN_BRIGHTNESS_EN only) sampled at SHOW entry
//   rom_addrx[5:0]      column address to the sprite ROM
//   rom_addry[4:0]      row address to the sprite ROM
//   rom_data0/1[23:0]   upper/lower half pixel, 1 clk after the address
//   panel_clk           panel shift clock (panel samples on rising edge)
//   panel_lat           latch strobe
//   panel_oe_n          output enable, active low
//   panel_row[4:0]      row select A..E
//   panel_rgb0/1[2:0]   {R,G,B} bits for the upper/lower half
//   frame_start         1-cycle pulse on the first SHIFT cycle of a frame
//   dbg_state[1:0]      current FSM state (0 IDLE, 1 SHIFT, 2 LATCH, 3 SHOW)
//
// There is no valid/ready handshake on this block: the ROM is a fixed-latency
// read (data valid exactly one clk after the address), and the panel has no
// back-pressure, so every transfer is purely schedule-driven.
// ---------------------------------------------------------------------------
module hub75_scan_ctrl #(
  parameter int COLOR_BITS = 4,
  parameter int BASE_ON    = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
`ifdef SCAN_BRIGHTNESS_EN
  input  logic [3:0]  brightness,
`endif
  output logic [5:0]  rom_addrx,
  output logic [4:0]  rom_addry,
  input  logic [23:0] rom_data0,
  input  logic [23:0] rom_data1,
  output logic        panel_clk,
  output logic        panel_lat,
  output logic        panel_oe_n,
  output logic [4:0]  panel_row,
  output logic [2:0]  panel_rgb0,
  output logic [2:0]  panel_rgb1,
  output logic        frame_start,
  output logic [1:0]  dbg_state
);

  // Plane index is exactly wide enough for COLOR_BITS planes (at least 1 bit).
  localparam int PW      = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1;
  // SHOW counter must hold the longest plane time without overflow.
  localparam int MAXLEN  = BASE_ON << (COLOR_BITS - 1);
  localparam int SW      = $clog2(MAXLEN + 1);
  localparam logic [PW-1:0] PLANE_LAST = PW'(COLOR_BITS - 1);
  // SHIFT runs 130 cycles: 64 columns x 2 clk plus ROM and output register.
  localparam logic [7:0] SHIFT_LAST = 8'd129;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2,
    SHOW  = 2'd3
  } state_t;

  state_t          state;
  logic [4:0]      row;
  logic [PW-1:0]   plane;
  logic [7:0]      sc;        // cycle index within SHIFT
  logic [SW-1:0]   show_cnt;  // cycle index within SHOW
  logic [SW-1:0]   on_len_q;  // oe-low cycles for the current SHOW

  logic [SW-1:0]   show_len;
  logic [SW-1:0]   on_len;
  logic [2:0]      bit_idx;

  assign dbg_state = state;
  assign show_len  = SW'(BASE_ON) << plane;
  assign bit_idx   = 3'(8 - COLOR_BITS) + 3'(plane);

`ifdef SCAN_BRIGHTNESS_EN
  localparam int PRW = SW + 5;
  logic [PRW-1:0] on_prod;
  always_comb begin
    on_prod = PRW'(show_len) * PRW'({1'b0, brightness} + 5'd1);
    on_len  = SW'(on_prod >> 4);
  end
`else
  assign on_len = show_len;
`endif

  // Pick one bit from each 8-bit channel of a 24'hRRGGBB pixel.
  function automatic logic [2:0] slice(input logic [23:0] d, input logic [2:0] idx);
    logic [4:0] i;
    i = {2'b00, idx};
    return {d[i + 5'd16], d[i + 5'd8], d[i]};
  endfunction

  // Column pipeline within SHIFT (sc = cycle index):
  //   cycle sc     : rom_addrx = sc>>1
  //   cycle sc+1   : rom_data holds that column
  //   cycle sc+2   : panel_rgb holds it
  // so column c is on panel_rgb during cycles 2c+2 and 2c+3, and panel_clk
  // is high only in cycle 2c+3 -- the rising edge sits mid-column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      row         <= '0;
      plane       <= '0;
      sc          <= '0;
      show_cnt    <= '0;
      on_len_q    <= '0;
      rom_addrx   <= '0;
      rom_addry   <= '0;
      panel_clk   <= 1'b0;
      panel_lat   <= 1'b0;
      panel_oe_n  <= 1'b1;
      panel_row   <= '0;
      panel_rgb0  <= '0;
      panel_rgb1  <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      case (state)
        IDLE: begin
          panel_clk  <= 1'b0;
          panel_lat  <= 1'b0;
          panel_oe_n <= 1'b1;
          if (enable) begin
            state       <= SHIFT;
            row         <= '0;
            plane       <= '0;
            sc          <= '0;
            rom_addrx   <= '0;
            rom_addry   <= '0;
            frame_start <= 1'b1;
          end
        end

        SHIFT: begin
          panel_oe_n <= 1'b1;
          if (sc < 8'd127) rom_addrx <= 6'((sc + 8'd1) >> 1);
          if (sc >= 8'd1 && sc <= 8'd128) begin
            panel_rgb0 <= slice(rom_data0, bit_idx);
            panel_rgb1 <= slice(rom_data1, bit_idx);
          end
          panel_clk <= (sc >= 8'd2) && (sc <= 8'd128) && !sc[0];
          if (sc == SHIFT_LAST) begin
            state     <= LATCH;
            panel_clk <= 1'b0;
            panel_lat <= 1'b1;
            panel_row <= row;   // oe_n is already high here
          end else begin
            sc <= sc + 8'd1;
          end
        end

        LATCH: begin
          state      <= SHOW;
          panel_lat  <= 1'b0;
          show_cnt   <= '0;
          on_len_q   <= on_len;
          panel_oe_n <= (on_len == '0);
        end

        SHOW: begin
          if (show_cnt == show_len - SW'(1)) begin
            panel_oe_n <= 1'b1;
            sc         <= '0;
            rom_addrx  <= '0;
            if (plane == PLANE_LAST) begin
              plane <= '0;
              if (row == 5'd31) begin
                row       <= '0;
                rom_addry <= '0;
                if (enable) begin
                  state       <= SHIFT;
                  frame_start <= 1'b1;
                end else begin
                  state      <= IDLE;
                  panel_row  <= '0;
                  panel_rgb0 <= '0;
                  panel_rgb1 <= '0;
                end
              end else begin
                row       <= row + 5'd1;
                rom_addry <= row + 5'd1;
                state     <= SHIFT;
              end
            end else begin
              plane <= plane + PW'(1);
              state <= SHIFT;
            end
          end else begin
            show_cnt   <= show_cnt + SW'(1);
            panel_oe_n <= !((show_cnt + SW'(1)) < on_len_q);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hub75_scan_ctrl
//
// Random sprite ROM contents; a frame-level reference model derived from the
// scan rules pushes the expected shift data, latch rows/times, oe-low run
// lengths and frame_start times into queues. A negedge monitor pops and
// compares whenever the panel presents the corresponding event.
// ---------------------------------------------------------------------------
module tb_hub75_scan_ctrl;
  localparam int CB     = 4;
  localparam int BO     = 32;
  localparam int FRAME  = 32128;
  localparam int BRIGHT = 7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
`ifdef SCAN_BRIGHTNESS_EN
  logic [3:0]  brightness;
`endif
  logic [5:0]  rom_addrx;
  logic [4:0]  rom_addry;
  logic [23:0] rom_data0, rom_data1;
  logic        panel_clk, panel_lat, panel_oe_n, frame_start;
  logic [4:0]  panel_row;
  logic [2:0]  panel_rgb0, panel_rgb1;
  logic [1:0]  dbg_state;

  hub75_scan_ctrl #(.COLOR_BITS(CB), .BASE_ON(BO)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
`ifdef SCAN_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .rom_addrx(rom_addrx), .rom_addry(rom_addry),
    .rom_data0(rom_data0), .rom_data1(rom_data1),
    .panel_clk(panel_clk), .panel_lat(panel_lat), .panel_oe_n(panel_oe_n),
    .panel_row(panel_row), .panel_rgb0(panel_rgb0), .panel_rgb1(panel_rgb1),
    .frame_start(frame_start), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- sprite ROM (1-cycle registered read) ----------------
  logic [23:0] mem0 [0:2047];
  logic [23:0] mem1 [0:2047];
  always @(posedge clk) begin
    rom_data0 <= mem0[{rom_addry, rom_addrx}];
    rom_data1 <= mem1[{rom_addry, rom_addrx}];
  end

  // ---------------- scoreboard ----------------
  logic [5:0] exp_shift_q[$];
  logic [4:0] exp_row_q[$];
  int         exp_lat_cyc_q[$];
  int         exp_oe_q[$];
  int         exp_fs_q[$];
  int         n_cmp  = 0;
  int         n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic miss(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: unexpected event, expected queue empty at %0t", name, $time);
  endtask

  // Reference model: a frame is 32 rows x CB planes; each row-plane is a
  // 130-cycle shift of 64 columns, a 1-cycle latch, and BO<<p cycles of show.
  task automatic build_frames(input int nframes);
    int t;
    int idx, len, on;
    logic [23:0] p0, p1;
    t = 0;
    for (int f = 0; f < nframes; f++) begin
      exp_fs_q.push_back(f * FRAME);
      for (int r = 0; r < 32; r++) begin
        for (int p = 0; p < CB; p++) begin
          idx = 8 - CB + p;
          for (int c = 0; c < 64; c++) begin
            p0 = mem0[r * 64 + c];
            p1 = mem1[r * 64 + c];
            exp_shift_q.push_back({p0[16 + idx], p0[8 + idx], p0[idx],
                                   p1[16 + idx], p1[8 + idx], p1[idx]});
          end
          exp_row_q.push_back(5'(r));
          exp_lat_cyc_q.push_back(t + 130);
          len = BO << p;
`ifdef SCAN_BRIGHTNESS_EN
          on = (len * (BRIGHT + 1)) >> 4;
`else
          on = len;
`endif
          if (on > 0) exp_oe_q.push_back(on);
          t += 131 + len;
        end
      end
    end
  endtask

  // ---------------- monitor ----------------
  logic       mon_on   = 1'b0;
  int         cyc      = 0;
  int         anchor   = 0;
  logic       anchored = 1'b0;
  int         edge_cnt = 0;
  int         lat_cnt  = 0;
  int         oe_run   = 0;
  int         fs_total = 0;
  logic       prev_clk = 1'b0, prev_oe = 1'b1, prev_fs = 1'b0;
  logic [4:0] prev_row = '0;
  logic [5:0] prev_rgb = '0;

  always @(negedge clk) begin
    cyc++;
    if (frame_start) fs_total++;
    if (mon_on && rst_n) begin
      if (frame_start) begin
        check("fs_width", 32'(prev_fs), 32'd0);
        if (!anchored) begin
          anchored = 1'b1;
          anchor   = cyc;
        end
        if (exp_fs_q.size() == 0) miss("frame_start");
        else check("frame_start_cycle", cyc - anchor, exp_fs_q.pop_front());
      end
      if (panel_clk && !prev_clk) begin
        check("rgb_stable", {26'd0, panel_rgb0, panel_rgb1}, {26'd0, prev_rgb});
        if (exp_shift_q.size() == 0) miss("shift_edge");
        else check("shift_rgb", {26'd0, panel_rgb0, panel_rgb1}, {26'd0, exp_shift_q.pop_front()});
        if (lat_cnt == 3 && edge_cnt == 5)
          check("col5_plane3", {26'd0, panel_rgb0, panel_rgb1}, 32'b100_001);
        edge_cnt++;
      end
      if (panel_lat) begin
        check("lat_edges", edge_cnt, 64);
        check("lat_oe_n", 32'(panel_oe_n), 32'd1);
        check("lat_clk", 32'(panel_clk), 32'd0);
        edge_cnt = 0;
        if (exp_row_q.size() == 0) miss("latch");
        else begin
          check("lat_row", 32'(panel_row), 32'(exp_row_q.pop_front()));
          check("lat_cycle", cyc - anchor, exp_lat_cyc_q.pop_front());
        end
        lat_cnt++;
      end
      if (!panel_oe_n) oe_run++;
      else if (!prev_oe) begin
        if (exp_oe_q.size() == 0) miss("oe_run");
        else check("oe_run_len", oe_run, exp_oe_q.pop_front());
        oe_run = 0;
      end
      if (panel_row != prev_row) check("row_chg_oe_n", 32'(panel_oe_n), 32'd1);
    end
    prev_clk = panel_clk;
    prev_oe  = panel_oe_n;
    prev_fs  = frame_start;
    prev_row = panel_row;
    prev_rgb = {panel_rgb0, panel_rgb1};
  end

  // ---------------- stimulus ----------------
  initial begin
    int fs_snap;
    rst_n  = 1'b1;
    enable = 1'b0;
`ifdef SCAN_BRIGHTNESS_EN
    brightness = 4'(BRIGHT);
`endif
    for (int i = 0; i < 2048; i++) begin
      mem0[i] = 24'($urandom);
      mem1[i] = 24'($urandom_range(0, 24'hFFFFFF));
    end
    mem0[5] = 24'h800000;
    mem1[5] = 24'h0000F0;

    #1 rst_n = 1'b0;
    #2;
    check("rst_oe_n", 32'(panel_oe_n), 32'd1);
    check("rst_lat", 32'(panel_lat), 32'd0);
    check("rst_clk", 32'(panel_clk), 32'd0);
    check("rst_fs", 32'(frame_start), 32'd0);
    check("rst_rgb", {26'd0, panel_rgb0, panel_rgb1}, 32'd0);
    check("rst_row", 32'(panel_row), 32'd0);
    check("rst_addr", {21'd0, rom_addry, rom_addrx}, 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_hold_state", 32'(dbg_state), 32'd0);
    check("idle_hold_oe_n", 32'(panel_oe_n), 32'd1);
    check("idle_hold_fs", fs_total, 0);

    // Two full frames; enable is dropped mid-way through the second.
    build_frames(2);
    mon_on = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 80000 && lat_cnt < 169; i++) @(negedge clk);
    check("reached_frame2_row10", 32'(lat_cnt >= 169), 32'd1);
    enable = 1'b0;

    for (int i = 0; i < 40000 && (lat_cnt < 256 || exp_oe_q.size() != 0); i++) @(negedge clk);
    repeat (1000) @(negedge clk);
    check("left_shift", exp_shift_q.size(), 0);
    check("left_lat", exp_row_q.size(), 0);
    check("left_oe", exp_oe_q.size(), 0);
    check("left_fs", exp_fs_q.size(), 0);
    check("end_idle_state", 32'(dbg_state), 32'd0);
    check("end_idle_oe_n", 32'(panel_oe_n), 32'd1);
    check("end_idle_row", 32'(panel_row), 32'd0);
    check("end_idle_rgb", {26'd0, panel_rgb0, panel_rgb1}, 32'd0);

    // Reset in the middle of SHOW.
    mon_on = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 1000 && panel_oe_n; i++) @(negedge clk);
    check("reached_show", 32'(panel_oe_n), 32'd0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_oe_n", 32'(panel_oe_n), 32'd1);
    check("async_lat_clk_fs", {29'd0, panel_lat, panel_clk, frame_start}, 32'd0);
    check("async_rgb_row", {21'd0, panel_rgb0, panel_rgb1, panel_row}, 32'd0);
    check("async_addr", {21'd0, rom_addry, rom_addrx}, 32'd0);
    check("async_state", 32'(dbg_state), 32'd0);
    enable = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
    fs_snap = fs_total;
    repeat (200) @(negedge clk);
    check("post_rst_state", 32'(dbg_state), 32'd0);
    check("post_rst_oe_n", 32'(panel_oe_n), 32'd1);
    check("post_rst_fs", fs_total, fs_snap);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
